// File: rtl/fc_decision_alarm.sv
// Turns the two FP16 logits from the FC stage into a per-frame human/background decision
// and a debounced alarm. The alarm level reflects the on/off hysteresis state directly.
module fc_decision_alarm #(
   parameter int DATAWIDTH        = 16,
   parameter int ALARM_ON_FRAMES  = 3,
   parameter int ALARM_OFF_FRAMES = 5,
   parameter int CNT_W            = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2*DATAWIDTH-1:0] fc_data,
   input  logic                   fc_done,
   input  logic                   alarm_clear,
   output logic                   decision_valid,
   output logic                   human,
   output logic                   nan_frame,
   output logic                   alarm,
   output logic                   nan_flag,
   output logic [CNT_W-1:0]       frame_count
);

   typedef enum logic {SAFE, ALARM} state_t;

   logic                   done_q;
   logic                   cap_v_q;
   logic [2*DATAWIDTH-1:0] data_q;
   logic                   dv_q, human_q, nan_q;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       hit_q, hit_d, miss_q, miss_d, frame_q, frame_d;
   logic                   nan_flag_q, nan_flag_d;

   logic                   rise;
   logic [15:0]            lg_h, lg_b, key_h, key_b;
   logic                   nan_h, nan_b, both_zero, cmp_human, cmp_nan;

   assign rise = fc_done & ~done_q;

   assign lg_h      = data_q[2*DATAWIDTH-1:DATAWIDTH];
   assign lg_b      = data_q[DATAWIDTH-1:0];
   assign nan_h     = (&lg_h[14:10]) & (|lg_h[9:0]);
   assign nan_b     = (&lg_b[14:10]) & (|lg_b[9:0]);
   assign both_zero = ~(|lg_h[14:0]) & ~(|lg_b[14:0]);
   // Sign-magnitude to offset-binary mapping makes FP16 ordering a plain unsigned compare.
   assign key_h     = lg_h[15] ? ~lg_h : (lg_h ^ 16'h8000);
   assign key_b     = lg_b[15] ? ~lg_b : (lg_b ^ 16'h8000);
   assign cmp_nan   = nan_h | nan_b;
   assign cmp_human = ~cmp_nan & ~both_zero & (key_h > key_b);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q  <= 1'b0;
         cap_v_q <= 1'b0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         human_q <= 1'b0;
         nan_q   <= 1'b0;
      end else begin
         done_q  <= fc_done;
         cap_v_q <= rise;
         if (rise) data_q <= fc_data;
         dv_q    <= cap_v_q;
         if (cap_v_q) begin
            human_q <= cmp_human;
            nan_q   <= cmp_nan;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= SAFE;
         hit_q      <= '0;
         miss_q     <= '0;
         frame_q    <= '0;
         nan_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         frame_q    <= frame_d;
         nan_flag_q <= nan_flag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hit_d      = hit_q;
      miss_d     = miss_q;
      frame_d    = frame_q;
      nan_flag_d = nan_flag_q;
      if (dv_q) frame_d = frame_q + 1'b1;
      // A clear at the same edge as a decision wins; only the frame counter still advances.
      if (alarm_clear) begin
         state_d    = SAFE;
         hit_d      = '0;
         miss_d     = '0;
         nan_flag_d = 1'b0;
      end else if (dv_q) begin
         if (nan_q) nan_flag_d = 1'b1;
         case (state_q)
            SAFE: begin
               if (human_q) begin
                  if (hit_q == CNT_W'(ALARM_ON_FRAMES - 1)) begin
                     state_d = ALARM;
                     hit_d   = '0;
                     miss_d  = '0;
                  end else begin
                     hit_d = hit_q + 1'b1;
                  end
               end else begin
                  hit_d = '0;
               end
            end
            ALARM: begin
               if (!human_q) begin
                  if (miss_q == CNT_W'(ALARM_OFF_FRAMES - 1)) begin
                     state_d = SAFE;
                     hit_d   = '0;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_q + 1'b1;
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: state_d = SAFE;
         endcase
      end
   end

   assign decision_valid = dv_q;
   assign human          = human_q;
   assign nan_frame      = nan_q;
   assign alarm          = (state_q == ALARM);
   assign nan_flag       = nan_flag_q;
   assign frame_count    = frame_q;

endmodule

// File: tb/tb_fc_decision_alarm.sv
// Self-checking bench for fc_decision_alarm: directed corner scenarios plus randomized frames
// checked against a real-valued FP16 comparison and a streak-based alarm model.
module tb_fc_decision_alarm;

   localparam int ON  = 3;
   localparam int OFF = 5;
   localparam int CW  = 8;

   logic          clk;
   logic          reset;
   logic [31:0]   fc_data;
   logic          fc_done;
   logic          alarm_clear;
   logic          decision_valid, human, nan_frame, alarm, nan_flag;
   logic [CW-1:0] frame_count;

   int checks = 0;
   int errors = 0;

   // Reference state: alarm level, length of current streak opposing it, sticky NaN, frames.
   bit            m_alarm;
   int            m_run;
   bit            m_nan_flag;
   logic [CW-1:0] m_frames;

   fc_decision_alarm #(
      .DATAWIDTH(16), .ALARM_ON_FRAMES(ON), .ALARM_OFF_FRAMES(OFF), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .fc_data(fc_data), .fc_done(fc_done),
      .alarm_clear(alarm_clear), .decision_valid(decision_valid), .human(human),
      .nan_frame(nan_frame), .alarm(alarm), .nan_flag(nan_flag), .frame_count(frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic real pow2(input int n);
      real v = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) v = v * 2.0;
      else        for (int i = 0; i < -n; i++) v = v / 2.0;
      return v;
   endfunction

   function automatic bit fp_is_nan(input logic [15:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
   endfunction

   function automatic real fp_val(input logic [15:0] x);
      int  e = int'(x[14:10]);
      int  m = int'(x[9:0]);
      real v;
      if (e == 31)     v = 1.0e30;
      else if (e == 0) v = real'(m) * pow2(-24);
      else             v = real'(1024 + m) * pow2(e - 25);
      return x[15] ? -v : v;
   endfunction

   function automatic bit exp_human(input logic [15:0] h, input logic [15:0] b);
      if (fp_is_nan(h) || fp_is_nan(b)) return 1'b0;
      return fp_val(h) > fp_val(b);
   endfunction

   function automatic void model_reset();
      m_alarm = 0; m_run = 0; m_nan_flag = 0; m_frames = '0;
   endfunction

   function automatic void model_clear();
      m_alarm = 0; m_run = 0; m_nan_flag = 0;
   endfunction

   function automatic void model_decision(input bit hu, input bit nn, input bit clr);
      m_frames = m_frames + 1'b1;
      if (clr) begin
         model_clear();
         return;
      end
      if (nn) m_nan_flag = 1;
      if (hu != m_alarm) begin
         m_run++;
         if (m_run == (m_alarm ? OFF : ON)) begin
            m_alarm = !m_alarm;
            m_run   = 0;
         end
      end else begin
         m_run = 0;
      end
   endfunction

   task automatic apply_reset();
      reset = 1'b0; fc_done = 1'b0; alarm_clear = 1'b0; fc_data = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   // One isolated frame; optionally pulses alarm_clear so it lands on the decision's update edge.
   task automatic do_frame(input logic [15:0] h, input logic [15:0] b, input bit clr);
      bit eh, en;
      eh = exp_human(h, b);
      en = fp_is_nan(h) || fp_is_nan(b);
      @(negedge clk);
      fc_data = {h, b}; fc_done = 1'b1;
      @(negedge clk);
      fc_done = 1'b0; fc_data = $urandom;
      checks++;
      if (decision_valid !== 1'b0) begin
         errors++; $display("FAIL early_valid got=%b exp=0", decision_valid);
      end
      @(negedge clk);
      checks++;
      if (decision_valid !== 1'b1 || human !== eh || nan_frame !== en) begin
         errors++;
         $display("FAIL decision h=%h b=%h got v/h/n=%b%b%b exp=1%b%b",
                  h, b, decision_valid, human, nan_frame, eh, en);
      end
      alarm_clear = clr;
      @(negedge clk);
      alarm_clear = 1'b0;
      model_decision(eh, en, clr);
      checks++;
      if (decision_valid !== 1'b0 || alarm !== m_alarm || frame_count !== m_frames ||
          nan_flag !== m_nan_flag) begin
         errors++;
         $display("FAIL update h=%h b=%h got v/a/nf/fc=%b%b%b/%0d exp=0%b%b/%0d",
                  h, b, decision_valid, alarm, nan_flag, frame_count, m_alarm, m_nan_flag, m_frames);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; fc_done = 1'b0; alarm_clear = 1'b0; fc_data = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({decision_valid, human, nan_frame, alarm, nan_flag} !== 5'b0 || frame_count !== '0) begin
         errors++;
         $display("FAIL reset_state got=%b%b%b%b%b fc=%0d exp=00000 fc=0",
                  decision_valid, human, nan_frame, alarm, nan_flag, frame_count);
      end
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      do_frame(16'h4000, 16'h3C00, 1'b0);
   endtask

   task automatic test_hysteresis();
      repeat (3) do_frame(16'h4000, 16'h3C00, 1'b0);
      checks++;
      if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_on got=%b exp=1", alarm); end
      repeat (4) do_frame(16'h3C00, 16'h4000, 1'b0);
      do_frame(16'h4000, 16'h3C00, 1'b0);
      repeat (4) do_frame(16'h3C00, 16'h4000, 1'b0);
      checks++;
      if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_hold got=%b exp=1", alarm); end
      do_frame(16'h3C00, 16'h4000, 1'b0);
      checks++;
      if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_off got=%b exp=0", alarm); end
   endtask

   task automatic test_compare_corners();
      do_frame(16'h0000, 16'h8000, 1'b0);
      do_frame(16'h8000, 16'h0000, 1'b0);
      do_frame(16'hC000, 16'hC400, 1'b0);
      do_frame(16'h7C00, 16'h7BFF, 1'b0);
      do_frame(16'h3C00, 16'h3C00, 1'b0);
      do_frame(16'hFC00, 16'hFBFF, 1'b0);
      do_frame(16'h0001, 16'h8001, 1'b0);
   endtask

   task automatic test_nan_clear();
      logic [CW-1:0] fc_before;
      do_frame(16'h4000, 16'h3C00, 1'b0);
      do_frame(16'h7E00, 16'h3C00, 1'b0);
      do_frame(16'h3C00, 16'h7C01, 1'b0);
      checks++;
      if (nan_flag !== 1'b1) begin errors++; $display("FAIL nan_sticky got=%b exp=1", nan_flag); end
      fc_before = m_frames;
      @(negedge clk); alarm_clear = 1'b1;
      @(negedge clk); alarm_clear = 1'b0;
      model_clear();
      checks++;
      if (nan_flag !== 1'b0 || alarm !== 1'b0 || frame_count !== fc_before) begin
         errors++;
         $display("FAIL clear got nf/a/fc=%b%b/%0d exp=00/%0d", nan_flag, alarm, frame_count, fc_before);
      end
   endtask

   task automatic test_done_level();
      int pulses;
      pulses = 0;
      @(negedge clk);
      fc_data = {16'h3C00, 16'h4000}; fc_done = 1'b1;
      repeat (20) begin @(negedge clk); if (decision_valid === 1'b1) pulses++; end
      fc_done = 1'b0;
      repeat (4) begin @(negedge clk); if (decision_valid === 1'b1) pulses++; end
      model_decision(1'b0, 1'b0, 1'b0);
      checks++;
      if (pulses != 1 || frame_count !== m_frames) begin
         errors++; $display("FAIL held_level got=%0d fc=%0d exp=1 fc=%0d", pulses, frame_count, m_frames);
      end
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (decision_valid === 1'b1) pulses++;
         fc_done = (i % 2 == 0);
      end
      fc_done = 1'b0;
      repeat (5) begin @(negedge clk); if (decision_valid === 1'b1) pulses++; end
      repeat (3) model_decision(1'b0, 1'b0, 1'b0);
      checks++;
      if (pulses != 3 || frame_count !== m_frames) begin
         errors++; $display("FAIL toggle got=%0d fc=%0d exp=3 fc=%0d", pulses, frame_count, m_frames);
      end
   endtask

   task automatic test_reset_mid_frame();
      int pulses;
      pulses = 0;
      repeat (3) do_frame(16'h4000, 16'h3C00, 1'b0);
      @(negedge clk);
      fc_data = {16'h4000, 16'h3C00}; fc_done = 1'b1;
      @(negedge clk);
      reset = 1'b0; fc_done = 1'b0;
      #1;
      checks++;
      if ({decision_valid, human, nan_frame, alarm, nan_flag} !== 5'b0 || frame_count !== '0) begin
         errors++;
         $display("FAIL async_reset got=%b%b%b%b%b fc=%0d exp=00000 fc=0",
                  decision_valid, human, nan_frame, alarm, nan_flag, frame_count);
      end
      repeat (2) begin @(negedge clk); if (decision_valid === 1'b1) pulses++; end
      reset = 1'b1;
      model_reset();
      repeat (4) begin @(negedge clk); if (decision_valid === 1'b1) pulses++; end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL discard got=%0d exp=0", pulses); end
      do_frame(16'h4000, 16'h3C00, 1'b0);
      do_frame(16'h4000, 16'h3C00, 1'b0);
      do_frame(16'h4000, 16'h3C00, 1'b1);
      checks++;
      if (alarm !== 1'b0 || frame_count !== 8'd3) begin
         errors++; $display("FAIL clear_wins got a=%b fc=%0d exp a=0 fc=3", alarm, frame_count);
      end
   endtask

   task automatic test_random();
      logic [15:0] specials [13];
      logic [15:0] h, b;
      specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7C01, 16'h3C00,
                   16'hBC00, 16'h0001, 16'h8001, 16'h7BFF, 16'hFBFF, 16'h0400};
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 3))
            0: begin h = 16'($urandom); b = 16'($urandom); end
            1: begin h = specials[$urandom_range(0, 12)]; b = specials[$urandom_range(0, 12)]; end
            2: begin h = 16'h4000 + 16'($urandom_range(0, 500)); b = 16'h3C00; end
            default: begin h = 16'hBC00; b = 16'h3C00 + 16'($urandom_range(0, 500)); end
         endcase
         do_frame(h, b, $urandom_range(0, 15) == 0);
      end
   endtask

   initial begin
      reset = 1'b0; fc_done = 1'b0; alarm_clear = 1'b0; fc_data = '0;
      model_reset();
      test_reset();
      test_single();
      test_hysteresis();
      test_compare_corners();
      test_nan_clear();
      test_done_level();
      test_reset_mid_frame();
      apply_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
